// File: rtl/memory_loader_pkg.sv
// Shared definitions for the program loader: bus/address widths common to the
// RAM and CPU control path, and the loader state encoding.
package memory_loader_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        VERIFY,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/memory_loader_addr_counter.sv
// RAM address register for the loader: synchronous clear, single-step increment
// and a flag marking the last location of the address space.
module memory_loader_addr_counter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  incr,
    output logic [ADDR_WIDTH-1:0] value,
    output logic                  terminal
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (incr) begin
            value <= value + 1'b1;
        end
    end

    assign terminal = (value == {ADDR_WIDTH{1'b1}});

endmodule

// File: rtl/memory_loader.sv
// Streams program bytes into the bus-attached RAM from address 0, reads each one
// back for verification, and holds the CPU halted until the load finishes.
module memory_loader #(
    parameter int ADDR_WIDTH = memory_loader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = memory_loader_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  mem_ie,
    output logic                  mem_oe,
    inout  wire  [DATA_WIDTH-1:0] bus,
    output logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [2:0]            fsm_state
);

    import memory_loader_pkg::*;

    // Input stream handshake: a byte transfers on a rising edge where
    // in_valid and in_ready are both high; in_ready is a registered output
    // that is high only in WAIT_BYTE and drops in the cycle after a transfer.

    loader_state_t         state;
    logic [DATA_WIDTH-1:0] byte_q;
    logic                  last_q;
    logic                  idle_like;
    logic                  read_match;
    logic                  addr_clear;
    logic                  addr_incr;
    logic                  addr_terminal;

    assign idle_like  = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign read_match = (bus == byte_q);
    assign addr_clear = idle_like && start;
    assign addr_incr  = (state == VERIFY) && read_match && !last_q && !addr_terminal;

    memory_loader_addr_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (addr_clear),
        .incr     (addr_incr),
        .value    (address),
        .terminal (addr_terminal)
    );

    // mem_ie is high only in WRITE, so it doubles as the bus drive enable.
    assign bus       = mem_ie ? byte_q : {DATA_WIDTH{1'bz}};
    assign busy      = cpu_halt;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mem_ie   <= 1'b0;
            mem_oe   <= 1'b0;
            cpu_halt <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            count    <= '0;
            checksum <= '0;
            byte_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= WAIT_BYTE;
                        in_ready <= 1'b1;
                        cpu_halt <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        count    <= '0;
                        checksum <= '0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid) begin
                        byte_q   <= in_data;
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        mem_ie   <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    mem_ie <= 1'b0;
                    mem_oe <= 1'b1;
                    state  <= VERIFY;
                end
                VERIFY: begin
                    mem_oe <= 1'b0;
                    if (!read_match) begin
                        state    <= ERROR;
                        error    <= 1'b1;
                        cpu_halt <= 1'b0;
                    end else begin
                        count    <= count + 1'b1;
                        checksum <= checksum + byte_q;
                        if (last_q) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_halt <= 1'b0;
                        end else if (addr_terminal) begin
                            // Image larger than the address space.
                            state    <= ERROR;
                            error    <= 1'b1;
                            cpu_halt <= 1'b0;
                        end else begin
                            state    <= WAIT_BYTE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    mem_ie   <= 1'b0;
                    mem_oe   <= 1'b0;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Bench for memory_loader: RAM model on the shared bus, table-driven and random
// loads checked against a stream-level model, plus reset/start corner sequences.
module tb_memory_loader;
    import memory_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  address;
    logic        mem_ie;
    logic        mem_oe;
    wire  [7:0]  bus;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  count;
    logic [7:0]  checksum;
    logic [2:0]  fsm_state;

    memory_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .address(address), .mem_ie(mem_ie), .mem_oe(mem_oe), .bus(bus),
        .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error),
        .count(count), .checksum(checksum), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // RAM model: writes on negedge, drives the bus while mem_oe is high
    logic [7:0] ram [256];
    logic       corrupt_en = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;
    assign bus = mem_oe ? ((corrupt_en && address == corrupt_addr) ? (ram[address] ^ 8'h01)
                                                                  : ram[address])
                        : 8'bz;

    int checks = 0;
    int failures = 0;
    int ie_cnt = 0;
    int seq_err = 0;
    int excl_err = 0;
    bit pending_oe = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every RAM write must carry the next accepted byte
    always @(negedge clk) begin
        if (mem_ie && mem_oe) excl_err++;
        if (mem_ie) begin
            ram[address] = bus;
            ie_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=0x%0h required=none", bus);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus != e) begin
                    failures++;
                    $display("FAIL write_data actual=0x%0h required=0x%0h", bus, e);
                end
            end
            pending_oe = !reset;
        end else if (pending_oe) begin
            if (!mem_oe) seq_err++;
            pending_oe = 1'b0;
        end
    end

    task automatic clear_mon();
        ie_cnt = 0; seq_err = 0; excl_err = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] data[$], input int last_at, input int gap,
                               output int accepted);
        bit got;
        accepted = 0;
        for (int i = 0; i < data.size(); i++) begin
            in_data = data[i];
            in_last = (i == last_at);
            in_valid = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            if (!got) break;
            @(posedge clk); #1;
            exp_q.push_back(data[i]);
            accepted++;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_end();
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (done || error) break;
        end
    endtask

    // Stream-level reference: what a correct loader ends up reporting
    function automatic void model(input logic [7:0] data[$], input int last_at, input int corrupt_at,
                                  output bit d, output bit e, output int cnt, output int csum,
                                  output int addr, output int acc);
        int n;
        int stop;
        bit has_last;
        n = data.size();
        has_last = (last_at >= 0 && last_at < n);
        stop = has_last ? last_at + 1 : n;
        d = 0; e = 0;
        if (corrupt_at >= 0 && corrupt_at < stop && corrupt_at < 256) begin
            e = 1; cnt = corrupt_at; addr = corrupt_at; acc = corrupt_at + 1;
        end else if (has_last && stop <= 256) begin
            d = 1; cnt = stop; addr = stop - 1; acc = stop;
        end else if (stop >= 256) begin
            e = 1; cnt = 256; addr = 255; acc = 256;
        end else begin
            cnt = stop; addr = stop; acc = stop;
        end
        csum = 0;
        for (int i = 0; i < cnt; i++) csum = (csum + data[i]) % 256;
    endfunction

    typedef struct {
        int nbytes;
        int pattern;
        int last_at;
        int corrupt_at;
        int gap;
        bit use_model;
        bit exp_done;
        bit exp_error;
        int exp_count;
        int exp_csum;
        int exp_addr;
        int exp_acc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0] data[$];
        int acc;
        bit md, me;
        int mc, ms, ma, mq;

        // clock/reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(fsm_state), int'(IDLE));
        check("rst_address", int'(address), 0);
        check("rst_count", int'(count), 0);
        check("rst_checksum", int'(checksum), 0);
        check("rst_ie_oe", {mem_ie, mem_oe}, 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_flags", {done, error, cpu_halt, busy}, 0);
        reset = 1'b0;

        vecs[0] = '{3,   0, 2,  -1, 0, 0, 1, 0, 3,   8'h47, 2,   3};
        vecs[1] = '{256, 1, 255, -1, 0, 0, 1, 0, 256, 8'h80, 255, 256};
        vecs[2] = '{257, 1, -1, -1, 1, 0, 0, 1, 256, 8'h80, 255, 256};
        vecs[3] = '{4,   3, 3,  1,  1, 0, 0, 1, 1,   8'h11, 1,   2};
        for (int v = 4; v < 10; v++) begin
            vecs[v].nbytes = $urandom_range(1, 24);
            vecs[v].pattern = 2;
            vecs[v].last_at = vecs[v].nbytes - 1;
            vecs[v].corrupt_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, vecs[v].nbytes - 1) : -1;
            vecs[v].gap = $urandom_range(0, 3);
            vecs[v].use_model = 1'b1;
        end

        for (int v = 0; v < 10; v++) begin
            data.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                case (vecs[v].pattern)
                    0: data.push_back((i == 0) ? 8'h3E : (i == 1) ? 8'h0A : 8'hFF);
                    1: data.push_back(8'(i));
                    3: data.push_back((i == 0) ? 8'h11 : (i == 1) ? 8'h55 : (i == 2) ? 8'h22 : 8'h33);
                    default: data.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            if (vecs[v].use_model) begin
                model(data, vecs[v].last_at, vecs[v].corrupt_at, md, me, mc, ms, ma, mq);
                vecs[v].exp_done = md; vecs[v].exp_error = me; vecs[v].exp_count = mc;
                vecs[v].exp_csum = ms; vecs[v].exp_addr = ma; vecs[v].exp_acc = mq;
            end
            clear_mon();
            corrupt_en = (vecs[v].corrupt_at >= 0);
            corrupt_addr = 8'(vecs[v].corrupt_at);
            pulse_start();
            check($sformatf("v%0d_busy", v), {busy, cpu_halt}, 2'b11);
            send_stream(data, vecs[v].last_at, vecs[v].gap, acc);
            wait_end();
            check($sformatf("v%0d_done", v), int'(done), int'(vecs[v].exp_done));
            check($sformatf("v%0d_error", v), int'(error), int'(vecs[v].exp_error));
            check($sformatf("v%0d_count", v), int'(count), vecs[v].exp_count);
            check($sformatf("v%0d_checksum", v), int'(checksum), vecs[v].exp_csum);
            check($sformatf("v%0d_address", v), int'(address), vecs[v].exp_addr);
            check($sformatf("v%0d_accepted", v), acc, vecs[v].exp_acc);
            check($sformatf("v%0d_ie_pulses", v), ie_cnt, vecs[v].exp_acc);
            check($sformatf("v%0d_oe_follow", v), seq_err, 0);
            check($sformatf("v%0d_exclusive", v), excl_err, 0);
            check($sformatf("v%0d_halt", v), {cpu_halt, busy, in_ready}, 0);
            begin
                int bad = 0;
                for (int i = 0; i < acc; i++) if (ram[i] != data[i]) bad++;
                check($sformatf("v%0d_ram", v), bad, 0);
            end
            corrupt_en = 1'b0;
        end

        // reset during the WRITE cycle of byte 4, then reload from 0
        clear_mon();
        data = '{8'h01, 8'h02, 8'h03};
        pulse_start();
        send_stream(data, -1, 0, acc);
        in_data = 8'h04; in_valid = 1'b1;
        begin
            bit got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            check("rst_mid_accept4", int'(got), 1);
        end
        @(posedge clk); #1;
        exp_q.push_back(8'h04);
        check("rst_mid_in_write", int'(mem_ie), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst_mid_state", int'(fsm_state), int'(IDLE));
        check("rst_mid_ie_oe", {mem_ie, mem_oe}, 0);
        check("rst_mid_count", int'(count), 0);
        check("rst_mid_halt", {cpu_halt, in_ready}, 0);
        check("rst_mid_ram3", int'(ram[3]), 8'h04);
        clear_mon();
        data = '{8'hC3, 8'h3C};
        pulse_start();
        check("reload_addr0", int'(address), 0);
        send_stream(data, 1, 1, acc);
        wait_end();
        check("reload_done", {done, error}, 2'b10);
        check("reload_count", int'(count), 2);
        check("reload_address", int'(address), 1);
        check("reload_ram0", int'(ram[0]), 8'hC3);

        // start pulsed while waiting for byte 2 must be ignored
        clear_mon();
        data = '{8'hA5};
        pulse_start();
        send_stream(data, -1, 0, acc);
        begin
            bit got = 1'b0;
            for (int w = 0; w < 12 && !got; w++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            check("start_busy_wait", int'(got), 1);
        end
        pulse_start();
        data = '{8'h5A};
        send_stream(data, 0, 0, acc);
        wait_end();
        check("start_busy_done", int'(done), 1);
        check("start_busy_count", int'(count), 2);
        check("start_busy_checksum", int'(checksum), 8'hFF);
        check("start_busy_address", int'(address), 1);
        check("start_busy_ie", ie_cnt, 2);
        check("start_busy_excl", excl_err + seq_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_loader.md
Name: memory_loader

Overview:
- Upstream stage of the 256x8 bus-attached RAM. Accepts a program byte stream over a valid/ready handshake and writes the bytes into consecutive RAM addresses, starting at address 0.
- Drives the RAM's address, ie and oe lines and the shared 8-bit bus.
- Reads back every byte and compares it with the byte written.
- Holds the CPU halted while loading. Reports a byte count, an additive checksum and done/error status.

Parameters:
- ADDR_WIDTH, 8, RAM address width; the address space is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8, width of the bus and of each stream byte.

Ports:
- clk  input  1  system clock; all state updates on posedge; the RAM writes on negedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR.
- in_valid  input  1  stream byte available.
- in_data  input  DATA_WIDTH  stream byte.
- in_last  input  1  qualifies the final byte of the stream; sampled with in_valid.
- in_ready  output  1  loader accepts in_data this cycle.
- address  output  ADDR_WIDTH  RAM address.
- mem_ie  output  1  RAM write enable.
- mem_oe  output  1  RAM output enable.
- bus  inout  DATA_WIDTH  shared bus; the loader drives it only in WRITE and is high-Z otherwise.
- cpu_halt  output  1  high whenever the state is not IDLE, DONE or ERROR.
- busy  output  1  same as cpu_halt.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.
- count  output  ADDR_WIDTH+1  number of bytes written and verified.
- checksum  output  DATA_WIDTH  sum of the verified bytes, modulo 2**DATA_WIDTH.

Behaviour:
- Reset (synchronous, takes priority over every other input):
  - state=IDLE, address=0, count=0, checksum=0.
  - mem_ie=0, mem_oe=0, bus=Z, in_ready=0.
  - done=0, error=0, cpu_halt=0.
  - A reset mid-load abandons the load. Bytes already written stay in RAM.
- States: IDLE, WAIT_BYTE, WRITE, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Go to WAIT_BYTE; clear address, count and checksum.
  - Clear done and error.
- WAIT_BYTE:
  - in_ready=1.
  - On in_valid: latch in_data and in_last into byte_q and last_q, then go to WRITE.
  - in_ready falls in the cycle after acceptance, so exactly one byte is accepted per handshake.
- WRITE (exactly 1 cycle):
  - bus=byte_q, mem_ie=1, mem_oe=0, address stable.
  - The RAM captures the byte on the negedge within this cycle.
  - Next state is VERIFY.
- VERIFY (exactly 1 cycle):
  - bus=Z, mem_oe=1, mem_ie=0, address unchanged.
  - At the closing posedge, compare bus with byte_q.
  - Mismatch: go to ERROR; address holds the failing location; count and checksum are not updated.
  - Match: count+=1, checksum+=byte_q (wraps), then:
    - last_q=1: go to DONE; address holds the last written location.
    - last_q=0 and address=2**ADDR_WIDTH-1: go to ERROR (overflow); count=2**ADDR_WIDTH.
    - Otherwise: address+=1, go to WAIT_BYTE.
- Bus exclusivity:
  - The loader never drives the bus while mem_oe=1.
  - mem_ie and mem_oe are never high together.
  - Both are registered outputs decoded from state; no glitches.
- Throughput: 3 cycles per byte minimum (WAIT_BYTE, WRITE, VERIFY). Latency from an accepted byte to the RAM write is 1 cycle.
- start is ignored while busy. in_valid is ignored outside WAIT_BYTE.
- DONE and ERROR persist until start or reset. count and checksum stay valid in both.
- All counters are unsigned. count is ADDR_WIDTH+1 bits so a full 256-byte image reads back as 256.

Decomposition:
- Shared package holds:
  - loader_state_t enum: IDLE, WAIT_BYTE, WRITE, VERIFY, DONE, ERROR.
  - Bus width constant DATA_WIDTH=8 and address width constant ADDR_WIDTH=8, shared with the RAM and the CPU control path.
- One natural sub-module: loader_addr_counter (address register with clear, increment and terminal-count flag).
- The FSM, the tri-state bus driver and the checksum stay in the top module.

Test Plan:
- Reset, then start, then stream 0x3E,0x0A,0xFF with in_last on 0xFF:
  - RAM[0..2]=3E,0A,FF.
  - done=1, count=3, checksum=0x47, address=2, cpu_halt=0.
  - mem_ie pulses exactly 3 times, each followed by one mem_oe cycle.
- Stream 256 bytes 0x00..0xFF, in_last on the 256th:
  - done=1, count=256, checksum=0x80, address=0xFF, error=0.
- Stream 257 bytes with no in_last:
  - After the 256th verify: error=1, count=256.
  - in_ready stays 0; the 257th byte is never accepted.
- Force a RAM read corruption: during the VERIFY of byte 2 (write 0x55), the bench drives 0x54 onto the bus.
  - error=1, address=1, count=1.
  - No further mem_ie.
- Assert reset in the WRITE cycle of byte 4:
  - Next cycle: IDLE, mem_ie=0, mem_oe=0, bus=Z, count=0.
  - A new start then reloads from address 0.
- Pulse start while in WAIT_BYTE, and assert in_valid during WRITE/VERIFY:
  - Both are ignored; each byte is written once; no bus contention (bus never X).
